freq_uart_reporter: RTL and testbench

- Downstream consumer of the low-frequency counter's 4-digit BCD result.
- Latches bcd3..bcd0 on a start pulse and formats them as ASCII with leading-zero suppression, followed by CR LF.
- Transmits the message over an 8N1 UART line, LSB first, so the measured frequency can be read on a host terminal.
- Provides a ready/done_tick handshake matching the counter's sub-units.

---
 rtl/freq_uart_reporter.sv | 142 ++++++++++++++
 tb/tb_freq_uart_reporter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/freq_uart_reporter.sv
// Serialises a latched 4-digit BCD value as ASCII (leading zeros suppressed)
// plus CR LF over an 8N1 UART line, LSB first.
module freq_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned TMR_W        = 13
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       start_amisha,
  input  logic [3:0] bcd3_amisha,
  input  logic [3:0] bcd2_amisha,
  input  logic [3:0] bcd1_amisha,
  input  logic [3:0] bcd0_amisha,
  output logic       tx_amisha,
  output logic       ready_amisha,
  output logic       done_tick_amisha
);

  typedef enum logic [1:0] {IDLE, STRT, DATA, STOP} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LF   = 3'd5;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       bitcnt;
  logic [2:0]       idx;
  logic [3:0]       d3, d2, d1, d0;
  logic [7:0]       shreg;
  logic [2:0]       first_idx;
  logic             bit_end;

  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] char_at(input logic [2:0] i, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c,
                                         input logic [3:0] e);
    case (i)
      3'd0:    return enc_digit(a);
      3'd1:    return enc_digit(b);
      3'd2:    return enc_digit(c);
      3'd3:    return enc_digit(e);
      3'd4:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Highest digit that is nonzero (or invalid); units digit is always sent.
  always_comb begin
    if (bcd3_amisha != 4'd0)      first_idx = 3'd0;
    else if (bcd2_amisha != 4'd0) first_idx = 3'd1;
    else if (bcd1_amisha != 4'd0) first_idx = 3'd2;
    else                          first_idx = 3'd3;
  end

  assign bit_end = (tmr == TMR_LAST);

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state            <= IDLE;
      tmr              <= '0;
      bitcnt           <= '0;
      idx              <= '0;
      d3               <= '0;
      d2               <= '0;
      d1               <= '0;
      d0               <= '0;
      shreg            <= '0;
      tx_amisha        <= 1'b1;
      ready_amisha     <= 1'b1;
      done_tick_amisha <= 1'b0;
    end else begin
      done_tick_amisha <= 1'b0;
      case (state)
        IDLE: begin
          tx_amisha    <= 1'b1;
          ready_amisha <= 1'b1;
          if (start_amisha) begin
            d3           <= bcd3_amisha;
            d2           <= bcd2_amisha;
            d1           <= bcd1_amisha;
            d0           <= bcd0_amisha;
            idx          <= first_idx;
            shreg        <= char_at(first_idx, bcd3_amisha, bcd2_amisha, bcd1_amisha, bcd0_amisha);
            tmr          <= '0;
            tx_amisha    <= 1'b0;
            ready_amisha <= 1'b0;
            state        <= STRT;
          end
        end
        STRT: begin
          if (bit_end) begin
            tmr       <= '0;
            bitcnt    <= '0;
            tx_amisha <= shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
            state     <= DATA;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            tmr <= '0;
            if (bitcnt == 3'd7) begin
              tx_amisha <= 1'b1;
              state     <= STOP;
            end else begin
              bitcnt    <= bitcnt + 3'd1;
              tx_amisha <= shreg[0];
              shreg     <= {1'b0, shreg[7:1]};
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            tmr <= '0;
            if (idx == IDX_LF) begin
              done_tick_amisha <= 1'b1;
              ready_amisha     <= 1'b1;
              state            <= IDLE;
            end else begin
              // Back-to-back characters: next start bit follows immediately.
              idx       <= idx + 3'd1;
              shreg     <= char_at(idx + 3'd1, d3, d2, d1, d0);
              tx_amisha <= 1'b0;
              state     <= STRT;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_uart_reporter.sv
// Directed bench for freq_uart_reporter: cycle-exact tx stream, handshake and
// reset checks at CLKS_PER_BIT=4, plus bit-period measurement at 5208.
module tb_freq_uart_reporter;

  localparam int unsigned CPB = 4;

  logic clk_amisha = 1'b0;
  logic reset_amisha, start_amisha, start_big;
  logic [3:0] bcd3_amisha, bcd2_amisha, bcd1_amisha, bcd0_amisha;
  logic tx_amisha, ready_amisha, done_tick_amisha;
  logic tx_big, ready_big, done_big;

  int checks = 0;
  int errors = 0;

  always #5 clk_amisha = ~clk_amisha;

  freq_uart_reporter #(.CLKS_PER_BIT(CPB), .TMR_W(3)) dut (
    .clk_amisha(clk_amisha), .reset_amisha(reset_amisha), .start_amisha(start_amisha),
    .bcd3_amisha(bcd3_amisha), .bcd2_amisha(bcd2_amisha), .bcd1_amisha(bcd1_amisha),
    .bcd0_amisha(bcd0_amisha), .tx_amisha(tx_amisha), .ready_amisha(ready_amisha),
    .done_tick_amisha(done_tick_amisha));

  freq_uart_reporter #(.CLKS_PER_BIT(5208), .TMR_W(13)) dut_big (
    .clk_amisha(clk_amisha), .reset_amisha(reset_amisha), .start_amisha(start_big),
    .bcd3_amisha(bcd3_amisha), .bcd2_amisha(bcd2_amisha), .bcd1_amisha(bcd1_amisha),
    .bcd0_amisha(bcd0_amisha), .tx_amisha(tx_big), .ready_amisha(ready_big),
    .done_tick_amisha(done_big));

  typedef struct packed {
    logic [3:0]      d3, d2, d1, d0;
    logic [2:0]      nchars;
    logic [5:0][7:0] chars;
    logic            glitch;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic [2:0] n,
                              input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] c3, input logic [7:0] c4, input logic [7:0] c5,
                              input logic g);
    vec_t v;
    v.d3 = a; v.d2 = b; v.d1 = c; v.d0 = d; v.nchars = n;
    v.chars[0] = c0; v.chars[1] = c1; v.chars[2] = c2;
    v.chars[3] = c3; v.chars[4] = c4; v.chars[5] = c5;
    v.glitch = g;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_amisha); #1;
  endtask

  // Pulse start, then compare tx/ready/done_tick every cycle against the ideal frame stream.
  task automatic run_msg(input vec_t v);
    int total, k, b, bad_tx, bad_rdy, bad_done;
    logic [7:0] ch;
    logic exp_tx;
    total = int'(v.nchars) * 10 * CPB;
    bad_tx = 0; bad_rdy = 0; bad_done = 0;
    bcd3_amisha = v.d3; bcd2_amisha = v.d2; bcd1_amisha = v.d1; bcd0_amisha = v.d0;
    start_amisha = 1'b1;
    cyc();
    start_amisha = 1'b0;
    bcd3_amisha = 4'h7; bcd2_amisha = 4'h7; bcd1_amisha = 4'h7; bcd0_amisha = 4'h7;
    for (int t = 1; t <= total; t++) begin
      if (v.glitch && t == 50) begin
        start_amisha = 1'b1;
        bcd3_amisha = 4'h9; bcd2_amisha = 4'h9; bcd1_amisha = 4'h9; bcd0_amisha = 4'h9;
      end else begin
        start_amisha = 1'b0;
      end
      k  = (t - 1) / (10 * CPB);
      b  = ((t - 1) / CPB) % 10;
      ch = v.chars[k];
      if (b == 0)      exp_tx = 1'b0;
      else if (b == 9) exp_tx = 1'b1;
      else             exp_tx = ch[b-1];
      if (tx_amisha !== exp_tx)     bad_tx++;
      if (ready_amisha !== 1'b0)    bad_rdy++;
      if (done_tick_amisha !== 1'b0) bad_done++;
      cyc();
    end
    start_amisha = 1'b0;
    check("tx_stream_bad_cycles", bad_tx, 0);
    check("ready_high_while_busy", bad_rdy, 0);
    check("done_tick_early", bad_done, 0);
    check("done_tick_at_end", done_tick_amisha, 1);
    check("ready_at_done", ready_amisha, 1);
    check("tx_idle_at_done", tx_amisha, 1);
    cyc();
    check("done_tick_single", done_tick_amisha, 0);
  endtask

  initial begin
    int n;
    vecs[0] = mk(4'd0, 4'd1, 4'd2, 4'd3, 3'd5, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00, 1'b0);
    vecs[1] = mk(4'd0, 4'd0, 4'd0, 4'd0, 3'd3, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[2] = mk(4'd9, 4'd9, 4'd9, 4'd9, 3'd6, 8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A, 1'b0);
    vecs[3] = mk(4'd0, 4'd4, 4'd0, 4'd0, 3'd5, 8'h34, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h00, 1'b0);
    vecs[4] = mk(4'd0, 4'hA, 4'd0, 4'd5, 3'd5, 8'h3F, 8'h30, 8'h35, 8'h0D, 8'h0A, 8'h00, 1'b0);
    vecs[5] = mk(4'd0, 4'd1, 4'd2, 4'd3, 3'd5, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00, 1'b1);
    vecs[6] = mk(4'd0, 4'd0, 4'd0, 4'hF, 3'd3, 8'h3F, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[7] = mk(4'd1, 4'd0, 4'd0, 4'd0, 3'd6, 8'h31, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A, 1'b0);

    reset_amisha = 1'b1; start_amisha = 1'b0; start_big = 1'b0;
    bcd3_amisha = 4'd0; bcd2_amisha = 4'd0; bcd1_amisha = 4'd0; bcd0_amisha = 4'd0;
    cyc(); cyc();
    reset_amisha = 1'b0;
    check("reset_tx", tx_amisha, 1);
    check("reset_ready", ready_amisha, 1);
    check("reset_done_tick", done_tick_amisha, 0);
    cyc();

    for (int i = 0; i < 8; i++) run_msg(vecs[i]);

    // Reset mid-frame at cycle 37 of a transfer.
    bcd3_amisha = 4'd0; bcd2_amisha = 4'd1; bcd1_amisha = 4'd2; bcd0_amisha = 4'd3;
    start_amisha = 1'b1;
    cyc();
    start_amisha = 1'b0;
    repeat (36) cyc();
    check("busy_before_reset", ready_amisha, 0);
    reset_amisha = 1'b1;
    cyc();
    reset_amisha = 1'b0;
    check("midreset_tx", tx_amisha, 1);
    check("midreset_ready", ready_amisha, 1);
    check("midreset_done_tick", done_tick_amisha, 0);
    run_msg(vecs[0]);

    // Start coincident with reset is dropped.
    reset_amisha = 1'b1; start_amisha = 1'b1;
    bcd3_amisha = 4'd1; bcd2_amisha = 4'd1; bcd1_amisha = 4'd1; bcd0_amisha = 4'd1;
    cyc();
    reset_amisha = 1'b0; start_amisha = 1'b0;
    check("rst_start_ready", ready_amisha, 1);
    check("rst_start_tx", tx_amisha, 1);
    cyc();
    check("rst_start_ready_next", ready_amisha, 1);
    check("rst_start_tx_next", tx_amisha, 1);

    // Full-rate instance: measure start bit and first data bit of '1' (0x31).
    bcd3_amisha = 4'd1; bcd2_amisha = 4'd0; bcd1_amisha = 4'd0; bcd0_amisha = 4'd0;
    start_big = 1'b1;
    cyc();
    start_big = 1'b0;
    check("big_ready_low", ready_big, 0);
    n = 0;
    while (tx_big === 1'b0 && n < 6000) begin n++; cyc(); end
    check("big_start_bit_cycles", n, 5208);
    n = 0;
    while (tx_big === 1'b1 && n < 6000) begin n++; cyc(); end
    check("big_data_bit0_cycles", n, 5208);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
